// File: rtl/pu_fifo_arbiter.sv
// Round-robin write arbiter and read port sharing one pu_fifo instance.
// One FIFO operation per cycle; occupancy is tracked here to block overflow/underflow.
module pu_fifo_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int FIFO_SIZE  = 3,
  parameter int NUM_WR     = 2,
  localparam int CNT_W     = $clog2(FIFO_SIZE + 1),
  localparam int PTR_W     = $clog2(NUM_WR)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WR*ATTR_WIDTH-1:0] wr_attr,
  output logic [NUM_WR-1:0]            wr_grant,
  input  logic                         rd_req,
  output logic                         rd_ack,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [ATTR_WIDTH-1:0]        rd_attr,
  output logic                         rd_valid,
  output logic                         fifo_signal_wr,
  output logic [DATA_WIDTH-1:0]        fifo_data_in,
  output logic [ATTR_WIDTH-1:0]        fifo_attr_in,
  output logic                         fifo_signal_oe,
  input  logic [DATA_WIDTH-1:0]        fifo_data_out,
  input  logic [ATTR_WIDTH-1:0]        fifo_attr_out,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty
);

  localparam logic [0:0] OP_READ  = 1'b0;
  localparam logic [0:0] OP_WRITE = 1'b1;

  logic [DATA_WIDTH-1:0] wr_word [NUM_WR];
  logic [ATTR_WIDTH-1:0] wr_tag  [NUM_WR];

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand;
  logic [0:0]       last_op;
  logic [CNT_W-1:0] count_reg;
  logic             can_wr;
  logic             can_rd;
  logic             do_wr;
  logic             do_rd;

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_unpack
      assign wr_word[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wr_tag[gi]  = wr_attr[gi*ATTR_WIDTH +: ATTR_WIDTH];
    end
  endgenerate

  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(FIFO_SIZE));
  assign empty = (count_reg == '0);

  // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    pick_idx = rr_ptr;
    cand     = '0;
    for (int k = NUM_WR; k >= 1; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_WR);
      if (wr_req[cand]) pick_idx = cand;
    end
  end

  assign can_wr = (|wr_req) && !full;
  assign can_rd = rd_req && !empty;

  // With both eligible, the op opposite to the previous one is taken; nothing is
  // accepted while reset is asserted.
  assign do_wr = rst && can_wr && (!can_rd || (last_op == OP_READ));
  assign do_rd = rst && can_rd && (!can_wr || (last_op == OP_WRITE));

  assign wr_grant = do_wr ? (NUM_WR'(1) << pick_idx) : '0;
  assign rd_ack   = do_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= PTR_W'(NUM_WR - 1);
      last_op        <= OP_READ;
      count_reg      <= '0;
      fifo_signal_wr <= 1'b0;
      fifo_data_in   <= '0;
      fifo_attr_in   <= '0;
      fifo_signal_oe <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      rd_attr        <= '0;
    end else begin
      fifo_signal_wr <= do_wr;
      fifo_data_in   <= do_wr ? wr_word[pick_idx] : '0;
      fifo_attr_in   <= do_wr ? wr_tag[pick_idx]  : '0;
      fifo_signal_oe <= do_rd;
      rd_valid       <= fifo_signal_oe;
      if (fifo_signal_oe) begin
        rd_data <= fifo_data_out;
        rd_attr <= fifo_attr_out;
      end
      if (do_wr) begin
        count_reg <= count_reg + CNT_W'(1);
        rr_ptr    <= pick_idx;
        last_op   <= OP_WRITE;
      end else if (do_rd) begin
        count_reg <= count_reg - CNT_W'(1);
        last_op   <= OP_READ;
      end
    end
  end

endmodule
